// File: rtl/shift_74hc165.sv
// ---------------------------------------------------------------------------
// shift_74hc165
//
// Reader for one NXP 74HC165 parallel-in/serial-out shift register, or for a
// daisy chain of them.  A read request pulses PL low to capture the parallel
// inputs. The captured bits are then clocked out of Q7, MSB first, and the
// assembled word is presented on data_out with a one-cycle valid strobe.
// CP is derived from clk, with every IC-side phase lasting DIV clk cycles, so
// CP never runs faster than clk/2.
//
// Parameters:
//   WIDTH  bits per transaction (8 x number of chained ICs), >= 1
//   DIV    clk cycles per IC-side phase (PL low, CP low, CP high), >= 1
//
// Ports:
//   clk             main clock, rising edge
//   rst             asynchronous active-high reset
//   rd_en           read request, only honoured in IDLE
//   data_out        last completed word, bit WIDTH-1 shifted out first
//   valid           one-cycle pulse when data_out has just been updated
//   busy            high while a transaction is in progress
//   serial_in       Q7 of the last IC in the chain
//   load_n          PL, active-low parallel load
//   register_clock  CP, shift clock (CE is tied low on the board)
// ---------------------------------------------------------------------------
module shift_74hc165 #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    input  logic             serial_in,
    output logic             load_n,
    output logic             register_clock
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [PW-1:0]    phase_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             phase_last;
    logic             last_bit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Every timed phase ends on the last of its DIV cycles.
    // The bit just being captured is the last one when WIDTH-1 bits are
    // already in, so a single-bit read goes straight from LOW to DONE.
    always_comb begin
        next_state = state;
        phase_last = (phase_cnt == PW'(DIV - 1));
        last_bit   = (bit_cnt == BW'(WIDTH - 1));
        // The cast keeps the low WIDTH bits, which also covers WIDTH=1.
        shift_next = WIDTH'({shift_reg, serial_in});

        case (state)
            IDLE: begin
                if (rd_en) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    next_state = last_bit ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    next_state = LOW;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase timing, bit counting and the capture shift register.
    // serial_in is sampled only on the last cycle of a LOW phase, which is
    // the latest point before CP rises and moves the IC on to its next bit.
    // The finished word goes to data_out on that same edge, so that it is
    // already stable in the DONE cycle while valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
        end else begin
            if ((state == LOAD || state == LOW || state == HIGH) && !phase_last) begin
                phase_cnt <= phase_cnt + PW'(1);
            end else begin
                phase_cnt <= '0;
            end

            if (state == IDLE && rd_en) begin
                bit_cnt <= '0;
            end else if (state == LOW && phase_last) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (state == LOW && phase_last) begin
                shift_reg <= shift_next;
                if (last_bit) begin
                    data_out <= shift_next;
                end
            end
        end
    end

    // Outputs are decoded from the next state and registered, so each output
    // reflects the state the block is in during that cycle without any
    // combinational path from an input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_n         <= 1'b1;
            register_clock <= 1'b0;
            busy           <= 1'b0;
            valid          <= 1'b0;
        end else begin
            load_n         <= (next_state != LOAD);
            register_clock <= (next_state == HIGH);
            busy           <= (next_state != IDLE);
            valid          <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_shift_74hc165.sv
// ---------------------------------------------------------------------------
// tb_shift_74hc165
//
// Self-checking bench for shift_74hc165. Four instances cover the
// configurations of interest:
//   A: WIDTH=8,  DIV=2   single reads, ignored requests, reset abort
//   B: WIDTH=16, DIV=2   two chained ICs
//   C: WIDTH=8,  DIV=1   back-to-back reads with rd_en held high
//   D: WIDTH=1,  DIV=3   single-bit read
// Each instance is attached to a behavioural 74HC165 chain model. PL low
// loads the parallel inputs, and a rising CP shifts toward Q7.
// Expected words and their valid cycles are pushed to a scoreboard when a
// request is driven, and they are popped when valid is seen.
// Cycle k is sampled on the falling edge after the k-th rising edge that
// follows the rd_en sample (cycle 0).
// ---------------------------------------------------------------------------
module tb_shift_74hc165;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        rd_a, ser_a, ld_a, cp_a, valid_a, busy_a;
    logic [7:0]  d_a;
    logic        rd_b, ser_b, ld_b, cp_b, valid_b, busy_b;
    logic [15:0] d_b;
    logic        rd_c, ser_c, ld_c, cp_c, valid_c, busy_c;
    logic [7:0]  d_c;
    logic        rd_d, ser_d, ld_d, cp_d, valid_d, busy_d;
    logic [0:0]  d_d;

    logic [7:0]  par_a = 8'h00;
    logic [15:0] par_b = 16'h0000;
    logic [7:0]  par_c = 8'h00;
    logic        par_d = 1'b0;

    logic [7:0]  chain_a = 8'h00;
    logic [15:0] chain_b = 16'h0000;
    logic [7:0]  chain_c = 8'h00;
    logic        chain_d = 1'b0;

    int cp_edges_a = 0, cp_edges_b = 0, cp_edges_c = 0, cp_edges_d = 0;
    int ld_pulses_a = 0, ld_pulses_b = 0, ld_pulses_c = 0, ld_pulses_d = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    shift_74hc165 #(.WIDTH(8), .DIV(2)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_a), .data_out(d_a), .valid(valid_a),
        .busy(busy_a), .serial_in(ser_a), .load_n(ld_a), .register_clock(cp_a));

    shift_74hc165 #(.WIDTH(16), .DIV(2)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_b), .data_out(d_b), .valid(valid_b),
        .busy(busy_b), .serial_in(ser_b), .load_n(ld_b), .register_clock(cp_b));

    shift_74hc165 #(.WIDTH(8), .DIV(1)) dut_c (
        .clk(clk), .rst(rst), .rd_en(rd_c), .data_out(d_c), .valid(valid_c),
        .busy(busy_c), .serial_in(ser_c), .load_n(ld_c), .register_clock(cp_c));

    shift_74hc165 #(.WIDTH(1), .DIV(3)) dut_d (
        .clk(clk), .rst(rst), .rd_en(rd_d), .data_out(d_d), .valid(valid_d),
        .busy(busy_d), .serial_in(ser_d), .load_n(ld_d), .register_clock(cp_d));

    // 74HC165 chain models: the falling PL edge captures the parallel inputs,
    // and a rising CP with PL high shifts one place toward Q7.
    always @(posedge cp_a or negedge ld_a) begin
        if (!ld_a) chain_a <= par_a;
        else       chain_a <= {chain_a[6:0], 1'b0};
    end
    always @(posedge cp_b or negedge ld_b) begin
        if (!ld_b) chain_b <= par_b;
        else       chain_b <= {chain_b[14:0], 1'b0};
    end
    always @(posedge cp_c or negedge ld_c) begin
        if (!ld_c) chain_c <= par_c;
        else       chain_c <= {chain_c[6:0], 1'b0};
    end
    always @(posedge cp_d or negedge ld_d) begin
        if (!ld_d) chain_d <= par_d;
        else       chain_d <= 1'b0;
    end

    assign ser_a = chain_a[7];
    assign ser_b = chain_b[15];
    assign ser_c = chain_c[7];
    assign ser_d = chain_d;

    always @(posedge cp_a) cp_edges_a++;
    always @(posedge cp_b) cp_edges_b++;
    always @(posedge cp_c) cp_edges_c++;
    always @(posedge cp_d) cp_edges_d++;
    always @(negedge ld_a) ld_pulses_a++;
    always @(negedge ld_b) ld_pulses_b++;
    always @(negedge ld_c) ld_pulses_c++;
    always @(negedge ld_d) ld_pulses_d++;

    task automatic push_expected(input logic [15:0] word, input int cyc);
        exp_t e;
        e.word = word;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0; rd_d = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ld_a, cp_a, busy_a, valid_a, d_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_outputs_a: got ld=%b cp=%b busy=%b valid=%b data=%h, required 1 0 0 0 00",
                     ld_a, cp_a, busy_a, valid_a, d_a);
        end
        checks++;
        if ({ld_b, cp_b, busy_b, valid_b, d_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_outputs_b: got ld=%b cp=%b busy=%b valid=%b data=%h, required 1 0 0 0 0000",
                     ld_b, cp_b, busy_b, valid_b, d_b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_c, cp_c, busy_c, valid_c, d_c} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL idle_outputs_c: got ld=%b cp=%b busy=%b valid=%b data=%h, required 1 0 0 0 00",
                     ld_c, cp_c, busy_c, valid_c, d_c);
        end
        checks++;
        if ({ld_d, cp_d, busy_d, valid_d, d_d} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL idle_outputs_d: got ld=%b cp=%b busy=%b valid=%b data=%h, required 1 0 0 0 0",
                     ld_d, cp_d, busy_d, valid_d, d_d);
        end
    endtask

    // One read on instance A with full per-cycle checking of PL and busy.
    task automatic test_single_read(input logic [7:0] value, input string tag);
        int   cp0, ld0;
        exp_t e;
        par_a = value;
        @(negedge clk);
        rd_a = 1'b1;
        cp0 = cp_edges_a;
        ld0 = ld_pulses_a;
        push_expected({8'h00, value}, 33);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) rd_a = 1'b0;
            checks++;
            if (ld_a !== ((k <= 2) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("[TB] FAIL %s_load_n: cycle %0d got %b, required %b", tag, k, ld_a, (k <= 2) ? 1'b0 : 1'b1);
            end
            checks++;
            if (busy_a !== ((k <= 33) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL %s_busy: cycle %0d got %b, required %b", tag, k, busy_a, (k <= 33) ? 1'b1 : 1'b0);
            end
            if (valid_a) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s_spurious_valid: cycle %0d got valid=1, required 0", tag, k);
                end else begin
                    e = sb_q.pop_front();
                    if ({8'h00, d_a} !== e.word || k != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL %s_read: got data=%h at cycle %0d, required data=%h at cycle %0d",
                                 tag, d_a, k, e.word[7:0], e.cyc);
                    end
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing_valid: got %0d outstanding reads, required 0", tag, sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (cp_edges_a - cp0 != 7) begin
            errors++;
            $display("[TB] FAIL %s_cp_edges: got %0d, required 7", tag, cp_edges_a - cp0);
        end
        checks++;
        if (ld_pulses_a - ld0 != 1) begin
            errors++;
            $display("[TB] FAIL %s_pl_pulses: got %0d, required 1", tag, ld_pulses_a - ld0);
        end
    endtask

    task automatic test_chain();
        int   cp0;
        exp_t e;
        par_b = 16'h1234;
        @(negedge clk);
        rd_b = 1'b1;
        cp0 = cp_edges_b;
        push_expected(16'h1234, 65);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 1) rd_b = 1'b0;
            if (valid_b) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL chain_spurious_valid: cycle %0d got valid=1, required 0", k);
                end else begin
                    e = sb_q.pop_front();
                    if (d_b !== e.word || k != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL chain_read: got data=%h at cycle %0d, required data=%h at cycle %0d",
                                 d_b, k, e.word, e.cyc);
                    end
                end
            end
            if (k == 66) begin
                checks++;
                if (busy_b !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL chain_busy_end: cycle 66 got %b, required 0", busy_b);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL chain_missing_valid: got %0d outstanding reads, required 0", sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (cp_edges_b - cp0 != 15) begin
            errors++;
            $display("[TB] FAIL chain_cp_edges: got %0d, required 15", cp_edges_b - cp0);
        end
    endtask

    task automatic test_back_to_back();
        int   cp0, ld0;
        logic exp_ld;
        exp_t e;
        par_c = 8'h00;
        @(negedge clk);
        rd_c = 1'b1;
        cp0 = cp_edges_c;
        ld0 = ld_pulses_c;
        push_expected(16'h0000, 17);
        push_expected(16'h00FF, 35);
        push_expected(16'h003C, 53);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5)  par_c = 8'hFF;
            if (k == 25) par_c = 8'h3C;
            if (k == 40) rd_c = 1'b0;
            exp_ld = (k == 1 || k == 19 || k == 37) ? 1'b0 : 1'b1;
            checks++;
            if (ld_c !== exp_ld) begin
                errors++;
                $display("[TB] FAIL b2b_load_n: cycle %0d got %b, required %b", k, ld_c, exp_ld);
            end
            if (valid_c) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_spurious_valid: cycle %0d got valid=1, required 0", k);
                end else begin
                    e = sb_q.pop_front();
                    if ({8'h00, d_c} !== e.word || k != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL b2b_read: got data=%h at cycle %0d, required data=%h at cycle %0d",
                                 d_c, k, e.word[7:0], e.cyc);
                    end
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_missing_valid: got %0d outstanding reads, required 0", sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (ld_pulses_c - ld0 != 3) begin
            errors++;
            $display("[TB] FAIL b2b_pl_pulses: got %0d, required 3", ld_pulses_c - ld0);
        end
        checks++;
        if (cp_edges_c - cp0 != 21) begin
            errors++;
            $display("[TB] FAIL b2b_cp_edges: got %0d, required 21", cp_edges_c - cp0);
        end
    endtask

    // Instance A currently holds 0xA5; extra requests mid-transaction must
    // neither restart nor queue a read, and the old word must hold.
    task automatic test_ignored_requests();
        int         ld0;
        logic [7:0] exp_d;
        exp_t       e;
        par_a = 8'h69;
        @(negedge clk);
        rd_a = 1'b1;
        ld0 = ld_pulses_a;
        push_expected(16'h0069, 33);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            rd_a = (k == 5 || k == 20 || k == 33) ? 1'b1 : 1'b0;
            exp_d = (k < 33) ? 8'hA5 : 8'h69;
            checks++;
            if (d_a !== exp_d) begin
                errors++;
                $display("[TB] FAIL ignore_data_hold: cycle %0d got %h, required %h", k, d_a, exp_d);
            end
            checks++;
            if (busy_a !== ((k <= 33) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL ignore_busy: cycle %0d got %b, required %b", k, busy_a, (k <= 33) ? 1'b1 : 1'b0);
            end
            if (valid_a) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL ignore_spurious_valid: cycle %0d got valid=1, required 0", k);
                end else begin
                    e = sb_q.pop_front();
                    if ({8'h00, d_a} !== e.word || k != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL ignore_read: got data=%h at cycle %0d, required data=%h at cycle %0d",
                                 d_a, k, e.word[7:0], e.cyc);
                    end
                end
            end
        end
        rd_a = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL ignore_missing_valid: got %0d outstanding reads, required 0", sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (ld_pulses_a - ld0 != 1) begin
            errors++;
            $display("[TB] FAIL ignore_pl_pulses: got %0d, required 1", ld_pulses_a - ld0);
        end
    endtask

    task automatic test_reset_abort();
        int valid_seen;
        test_single_read(8'h5A, "prior_read");
        par_a = 8'h0F;
        @(negedge clk);
        rd_a = 1'b1;
        push_expected(16'h000F, 33);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) rd_a = 1'b0;
        end
        rst = 1'b1;
        // The reset abort removes the pending read from the scoreboard.
        sb_q.delete();
        #1;
        checks++;
        if ({ld_a, cp_a, busy_a, valid_a, d_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got ld=%b cp=%b busy=%b valid=%b data=%h, required 1 0 0 0 00",
                     ld_a, cp_a, busy_a, valid_a, d_a);
        end
        @(negedge clk);
        rst = 1'b0;
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_a) valid_seen++;
        end
        checks++;
        if (valid_seen != 0 || d_a !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_no_valid: got %0d valid pulses, data=%h, required 0 pulses, data=00",
                     valid_seen, d_a);
        end
        test_single_read(8'hC3, "after_reset");
    endtask

    task automatic test_width1();
        int   cp0;
        exp_t e;
        par_d = 1'b1;
        @(negedge clk);
        rd_d = 1'b1;
        cp0 = cp_edges_d;
        push_expected(16'h0001, 7);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) rd_d = 1'b0;
            checks++;
            if (ld_d !== ((k <= 3) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("[TB] FAIL w1_load_n: cycle %0d got %b, required %b", k, ld_d, (k <= 3) ? 1'b0 : 1'b1);
            end
            if (valid_d) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL w1_spurious_valid: cycle %0d got valid=1, required 0", k);
                end else begin
                    e = sb_q.pop_front();
                    if ({15'h0000, d_d} !== e.word || k != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL w1_read: got data=%h at cycle %0d, required data=%h at cycle %0d",
                                 d_d, k, e.word[0], e.cyc);
                    end
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL w1_missing_valid: got %0d outstanding reads, required 0", sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (cp_edges_d - cp0 != 0) begin
            errors++;
            $display("[TB] FAIL w1_cp_edges: got %0d, required 0", cp_edges_d - cp0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read(8'hA5, "single");
        test_chain();
        test_back_to_back();
        test_ignored_requests();
        test_width1();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
